// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD counter with programmable terminal count, up/down direction,
// synchronous load with range checking, 74160-style cascade enables and a binary view.
module bcd_mod_counter #(
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned MOD_MAX = 20,
    localparam int unsigned BIN_W  = (MOD_MAX > 1) ? $clog2(MOD_MAX + 1) : 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  sclr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  enp,
    input  logic                  ent,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   q,
    output logic [BIN_W-1:0]      qbin,
    output logic                  rco,
    output logic                  err
);

    localparam int unsigned W = 4 * DIGITS;

    function automatic logic [W-1:0] to_bcd(input int unsigned v);
        logic [W-1:0] r;
        int unsigned  t;
        r = '0;
        t = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t           = t / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MOD_BCD = to_bcd(MOD_MAX);

    logic [W-1:0] q_q, q_d, q_inc, q_dec;
    logic         err_q, err_d;
    logic         data_ok, at_max, at_zero;
    logic         carry, borrow;
    logic [3:0]   dig;
    logic [BIN_W-1:0] qbin_acc;

    assign at_max  = (q_q == MOD_BCD);
    assign at_zero = (q_q == '0);

    // With every digit in 0..9, a plain magnitude compare of BCD words matches decimal order.
    always_comb begin
        data_ok = (data <= MOD_BCD);
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (data[4*i +: 4] > 4'd9) data_ok = 1'b0;
        end
    end

    always_comb begin
        q_inc  = q_q;
        q_dec  = q_q;
        carry  = 1'b1;
        borrow = 1'b1;
        dig    = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dig = q_q[4*i +: 4];
            if (carry) begin
                if (dig == 4'd9) begin
                    q_inc[4*i +: 4] = 4'd0;
                end else begin
                    q_inc[4*i +: 4] = dig + 4'd1;
                    carry           = 1'b0;
                end
            end
            if (borrow) begin
                if (dig == 4'd0) begin
                    q_dec[4*i +: 4] = 4'd9;
                end else begin
                    q_dec[4*i +: 4] = dig - 4'd1;
                    borrow          = 1'b0;
                end
            end
        end
    end

    always_comb begin
        q_d   = q_q;
        err_d = 1'b0;
        if (sclr) begin
            q_d = '0;
        end else if (load) begin
            if (data_ok) q_d   = data;
            else         err_d = 1'b1;
        end else if (enp && ent) begin
            if (up) q_d = at_max  ? '0      : q_inc;
            else    q_d = at_zero ? MOD_BCD : q_dec;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_q   <= '0;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            err_q <= err_d;
        end
    end

    // Horner evaluation; modular arithmetic in BIN_W bits is exact because Q never exceeds MOD_MAX.
    always_comb begin
        qbin_acc = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            qbin_acc = qbin_acc * BIN_W'(10) + BIN_W'(q_q[4*(int'(DIGITS)-1-i) +: 4]);
        end
    end

    assign q    = q_q;
    assign err  = err_q;
    assign qbin = qbin_acc;
    assign rco  = ent & (up ? at_max : at_zero);

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench: driver pushes expected outputs from a decimal-arithmetic model,
// a monitor pops and compares on every falling edge.
module tb_bcd_mod_counter;

    logic        clk;
    logic        clr, sclr, load, enp, ent, up;
    logic [7:0]  data;
    logic [7:0]  q;
    logic [4:0]  qbin;
    logic        rco, err;

    logic        load3;
    logic [11:0] data3;
    logic [11:0] q3;
    logic [9:0]  qbin3;
    logic        rco3, err3;

    logic [3:0]  qlo, qhi, qbinlo, qbinhi;
    logic        rcolo, rcohi, errlo, errhi;

    bcd_mod_counter #(.DIGITS(2), .MOD_MAX(20)) dut (
        .clk(clk), .clr(clr), .sclr(sclr), .load(load), .data(data), .enp(enp),
        .ent(ent), .up(up), .q(q), .qbin(qbin), .rco(rco), .err(err)
    );

    bcd_mod_counter #(.DIGITS(3), .MOD_MAX(999)) dut3 (
        .clk(clk), .clr(clr), .sclr(1'b0), .load(load3), .data(data3), .enp(1'b1),
        .ent(1'b1), .up(1'b1), .q(q3), .qbin(qbin3), .rco(rco3), .err(err3)
    );

    bcd_mod_counter #(.DIGITS(1), .MOD_MAX(9)) dut_lo (
        .clk(clk), .clr(clr), .sclr(1'b0), .load(1'b0), .data(4'h0), .enp(1'b1),
        .ent(1'b1), .up(1'b1), .q(qlo), .qbin(qbinlo), .rco(rcolo), .err(errlo)
    );

    bcd_mod_counter #(.DIGITS(1), .MOD_MAX(9)) dut_hi (
        .clk(clk), .clr(clr), .sclr(1'b0), .load(1'b0), .data(4'h0), .enp(1'b1),
        .ent(rcolo), .up(1'b1), .q(qhi), .qbin(qbinhi), .rco(rcohi), .err(errhi)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       tag;
        logic [7:0]  q;
        logic [4:0]  qbin;
        logic        rco;
        logic        err;
        logic [11:0] q3;
        logic [9:0]  qbin3;
        logic        rco3;
        logic        err3;
        logic [7:0]  qc;
        int          qbinc;
        logic        rcoc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state kept as plain decimal integers.
    int mv, me, m3v, m3e, mc;
    logic       next_load3;
    logic [11:0] next_data3;

    function automatic logic [31:0] bcd(input int v);
        logic [31:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic void model_reset();
        mv = 0; me = 0; m3v = 0; m3e = 0; mc = 0;
    endfunction

    function automatic void model_edge();
        int d1, d0, e2, e1, e0;
        if (sclr) begin
            mv = 0; me = 0;
        end else if (load) begin
            d1 = int'(data[7:4]);
            d0 = int'(data[3:0]);
            if (d1 <= 9 && d0 <= 9 && d1 * 10 + d0 <= 20) begin
                mv = d1 * 10 + d0; me = 0;
            end else begin
                me = 1;
            end
        end else begin
            me = 0;
            if (enp && ent) begin
                if (up) mv = (mv == 20) ? 0 : mv + 1;
                else    mv = (mv == 0) ? 20 : mv - 1;
            end
        end
        if (load3) begin
            e2 = int'(data3[11:8]); e1 = int'(data3[7:4]); e0 = int'(data3[3:0]);
            if (e2 <= 9 && e1 <= 9 && e0 <= 9) begin
                m3v = e2 * 100 + e1 * 10 + e0; m3e = 0;
            end else begin
                m3e = 1;
            end
        end else begin
            m3e = 0;
            m3v = (m3v + 1) % 1000;
        end
        mc = (mc + 1) % 100;
    endfunction

    function automatic void push(input string tag);
        exp_t e;
        e.tag   = tag;
        e.q     = 8'(bcd(mv));
        e.qbin  = 5'(mv);
        e.rco   = ent && (up ? (mv == 20) : (mv == 0));
        e.err   = me[0];
        e.q3    = 12'(bcd(m3v));
        e.qbin3 = 10'(m3v);
        e.rco3  = (m3v == 999);
        e.err3  = m3e[0];
        e.qc    = 8'(bcd(mc));
        e.qbinc = mc;
        e.rcoc  = (mc == 99);
        sb.push_back(e);
    endfunction

    task automatic cyc(input logic c, input logic s, input logic l, input logic [7:0] d,
                       input logic p, input logic t, input logic u, input string tag);
        @(posedge clk);
        #2;
        if (clr) model_edge();
        if (!c) model_reset();
        clr = c; sclr = s; load = l; data = d; enp = p; ent = t; up = u;
        load3 = next_load3; data3 = next_data3; next_load3 = 1'b0;
        push(tag);
    endtask

    task automatic chk(input string name, input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%s] @%0t: got %0h expected %0h", name, tag, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q",     e.tag, 32'(q),     32'(e.q));
                chk("qbin",  e.tag, 32'(qbin),  32'(e.qbin));
                chk("rco",   e.tag, 32'(rco),   32'(e.rco));
                chk("err",   e.tag, 32'(err),   32'(e.err));
                chk("q3",    e.tag, 32'(q3),    32'(e.q3));
                chk("qbin3", e.tag, 32'(qbin3), 32'(e.qbin3));
                chk("rco3",  e.tag, 32'(rco3),  32'(e.rco3));
                chk("err3",  e.tag, 32'(err3),  32'(e.err3));
                chk("casq",  e.tag, 32'({qhi, qlo}), 32'(e.qc));
                chk("casbin", e.tag, 32'(qbinlo) + 32'(qbinhi) * 10, 32'(e.qbinc));
                chk("casrco", e.tag, 32'(rcohi), 32'(e.rcoc));
                chk("caserr", e.tag, 32'(errlo | errhi), 32'd0);
            end
        end
    end

    initial begin : driver
        logic [7:0] d;
        model_reset();
        next_load3 = 1'b0; next_data3 = '0;
        clr = 1'b0; sclr = 1'b0; load = 1'b0; data = '0;
        enp = 1'b0; ent = 1'b1; up = 1'b0;
        load3 = 1'b0; data3 = '0;
        push("reset_down");
        cyc(0, 0, 0, 8'h00, 0, 1, 1, "reset_up");
        cyc(1, 0, 0, 8'h00, 1, 1, 1, "release");
        for (int i = 0; i < 22; i++) cyc(1, 0, 0, 8'h00, 1, 1, 1, "upcount");

        cyc(1, 0, 1, 8'h01, 0, 0, 0, "load01");
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 8'h00, 1, 1, 0, "down");
        cyc(1, 0, 0, 8'h00, 0, 0, 0, "down_settle");

        cyc(1, 0, 1, 8'h15, 0, 1, 1, "load15");
        cyc(1, 0, 1, 8'h21, 0, 1, 1, "load21");
        cyc(1, 0, 1, 8'h1A, 0, 1, 1, "load1A");
        cyc(1, 0, 1, 8'h12, 1, 1, 1, "load_en");
        cyc(1, 0, 0, 8'h00, 0, 1, 1, "loaded12");
        cyc(1, 0, 1, 8'h20, 0, 1, 1, "load20");
        cyc(1, 0, 0, 8'h00, 0, 1, 1, "hold_enp0");
        cyc(1, 0, 0, 8'h00, 0, 1, 1, "hold_enp0");
        cyc(1, 0, 0, 8'h00, 1, 0, 1, "ent0");
        cyc(1, 0, 0, 8'h00, 1, 0, 1, "ent0");
        cyc(1, 1, 1, 8'h12, 1, 1, 1, "sclr_load");
        cyc(1, 0, 0, 8'h00, 0, 1, 1, "after_sclr");

        cyc(1, 0, 1, 8'h17, 0, 1, 1, "load17");
        cyc(1, 0, 1, 8'h25, 1, 1, 1, "bad_load_en");
        cyc(0, 0, 0, 8'h00, 1, 1, 1, "async_clr");
        cyc(0, 0, 0, 8'h00, 1, 1, 1, "clr_held");
        cyc(1, 0, 0, 8'h00, 1, 1, 1, "clr_release");
        cyc(1, 0, 0, 8'h00, 1, 1, 1, "first_count");

        next_load3 = 1'b1; next_data3 = 12'h990;
        for (int i = 0; i < 14; i++) cyc(1, 0, 0, 8'h00, 0, 0, 1, "wrap3");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) d = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
            else d = 8'($urandom);
            cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 5) == 0), d, ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) != 0), 1'($urandom), "random");
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_mod_counter.md
# bcd_mod_counter

Parametrised synchronous multi-digit BCD counter with a programmable modulus, up/down direction, synchronous parallel load, cascadable enables and ripple-carry output, plus a binary view of the count. It is the general-purpose successor to the fixed two-digit 0–20 BCD counter. It serves as the timing and sequencing counter feeding display decoders and the binary datapath.

## Interface
Parameters:
- DIGITS, 2, number of BCD digits (1–8).
- MOD_MAX, 20, terminal count in decimal (1 to 10^DIGITS−1). Up-count sequence is 0..MOD_MAX.
- Derived localparam BIN_W = $clog2(MOD_MAX+1), with a minimum of 1.

Ports:
- CLK, in, 1, sole clock, rising edge.
- CLR, in, 1, asynchronous active-low reset.
- SCLR, in, 1, synchronous clear, active high.
- LOAD, in, 1, synchronous parallel load, active high.
- DATA, in, 4*DIGITS, BCD load value. Digit i is DATA[4i+3:4i], and digit 0 is the least significant.
- ENP, in, 1, count enable (parallel).
- ENT, in, 1, count enable (trickle). Also gates RCO.
- UP, in, 1, direction: 1 = up, 0 = down.
- Q, out, 4*DIGITS, registered BCD count, same digit order as DATA.
- QBIN, out, BIN_W, binary value of Q (combinational from Q).
- RCO, out, 1, ripple-carry out (combinational).
- ERR, out, 1, registered one-cycle flag indicating that a load was rejected.

## Operation
- Priority on each rising edge:
  1. SCLR
  2. LOAD
  3. Count
  4. Hold
- CLR low overrides all of the above, asynchronously.
- SCLR: Q←0 and ERR←0.
- LOAD: evaluated regardless of ENP/ENT and UP.
  - DATA is valid when every digit is ≤9 and the decimal value is ≤MOD_MAX. A valid DATA gives Q←DATA and ERR←0.
  - Invalid DATA is rejected: Q holds and ERR←1 for exactly one cycle.
- Count: occurs only when ENP & ENT = 1 and LOAD = SCLR = 0.
  - Up: if Q==MOD_MAX then Q←0. Otherwise decimal increment: a digit at 9 becomes 0 and carries into the next digit.
  - Down: if Q==0 then Q←MOD_MAX. Otherwise decimal decrement: a digit at 0 becomes 9 and borrows from the next digit.
- Hold: when ENP & ENT = 0, Q is unchanged.
- ERR is 0 on every cycle other than a rejected load.
- RCO = ENT & (UP ? Q==MOD_MAX : Q==0). RCO is independent of ENP, so cascading is 74160-style: RCO of stage n drives ENT of stage n+1.
- QBIN = Σ digit_i·10^i. It is always ≤MOD_MAX, so it always fits BIN_W.
- Q never holds a non-BCD digit or a value above MOD_MAX in any reachable state.

## Timing
- Reset values: while CLR is low, Q = 0, ERR = 0, QBIN = 0, and RCO = ENT & ~UP (terminal at 0 in down mode).
- CLR assertion takes effect immediately. On release, counting resumes on the first rising edge at which CLR is high.
- Load latency and count latency are each 1 cycle: the new value is visible after the edge.
- RCO and QBIN are combinational from Q, ENT and UP, with no register stage.
- Wrap-around occurs in a single cycle (MOD_MAX→0 or 0→MOD_MAX) with no intermediate state.
- A UP change takes effect at the next edge. RCO follows UP immediately.
- Simultaneous events:
  - LOAD together with ENP & ENT: the load wins.
  - SCLR together with LOAD: the clear wins, and ERR = 0.
  - An invalid LOAD together with the enables: Q holds (it does not count), and ERR = 1.
- CLR asserted mid-count, mid-load or during ERR: all registers go to 0 immediately.

## Test plan
All scenarios use DIGITS=2 and MOD_MAX=20 unless noted.
- Reset and up-count:
  - Pulse CLR low, then ENP = ENT = UP = 1 for 22 edges. Required: Q steps 0x00..0x09, 0x10..0x19, 0x20, 0x00, 0x01.
  - QBIN tracks the decimal value at every step.
  - RCO = 1 only while Q = 0x20.
- Down-count and wrap: load 0x01, then UP = 0 with enables high for 3 edges. Required: Q = 0x00, then 0x20, then 0x19. RCO = 1 only at 0x00.
- Load validation:
  - LOAD 0x15: Q = 0x15, ERR = 0.
  - LOAD 0x21: Q holds at 0x15 and ERR = 1 for one cycle.
  - LOAD 0x1A: rejected, with the same response.
  - LOAD asserted with enables high: loads, with no count in the same cycle.
- Enables and priority:
  - ENP = 0 with ENT = 1: Q holds and RCO stays live.
  - ENT = 0: RCO = 0 even at Q = 0x20.
  - SCLR together with LOAD 0x12: Q = 0x00.
- Asynchronous reset mid-operation: assert CLR low between edges while Q = 0x17 and ERR = 1. Required: Q = 0 and ERR = 0 before the next edge, and no count until the first edge after CLR returns high.
- Cascade and parameter sweep:
  - Two instances with RCO→ENT, DIGITS=1 and MOD_MAX=9 each: the pair counts 00..99.
  - Separately, DIGITS=3 and MOD_MAX=999: Q wraps from 0x999 to 0x000, and QBIN reaches 999.
